dbf_ch_param: RTL and testbench
===============================

Name: dbf_ch_param

Overview:
Parametrised per-channel digital beamforming datapath: coarse delay, fine interpolation and apodization in one block.
- Coarse delay via circular sample buffer; fine delay via 2-tap linear interpolation; apodization via signed multiply with rounding.
- Delay is dynamic-focus: per-zone {coarse, frac} LUT, zone advancing every ZONE_LEN accepted samples.
- One instance per array element; outputs feed the channel summation tree.

Parameters:
INPUT_WD, 14, signed ADC sample width
APO_WD, 16, signed apodization weight width
APO_SHIFT, 12, right shift after apodization multiply (weight 1.0 = 2^APO_SHIFT)
OUT_WD, 16, signed output width
BUF_AW, 7, sample buffer address width (depth 2^BUF_AW)
CD_WD, 7, coarse delay field width
FD_WD, 4, fine delay fraction width
LUT_AW, 6, delay LUT address width
ZONE_LEN, 16, accepted samples per focal zone

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
tx_en  in  1  transmit active; samples ignored while high
start  in  1  receive window; high = RUN
din  in  INPUT_WD  signed channel sample
din_valid  in  1  sample strobe; accepted when din_valid & ~tx_en & start
apo_din  in  APO_WD  signed apodization weight, sampled with the sample
lut_we  in  1  delay LUT write enable
lut_addr  in  LUT_AW  delay LUT write address
lut_din  in  CD_WD+FD_WD  {coarse, frac}
dout  out  OUT_WD  signed beamformed channel sample
dout_valid  out  1  dout qualifier
cd_dout  out  INPUT_WD  coarse-delayed sample (debug)

Behaviour:
- Reset: dout=0, dout_valid=0, cd_dout=0; write pointer, sample count n, zone counter, zone sample counter, pipeline valids=0; FSM=IDLE. LUT and buffer contents undefined.
- FSM IDLE->RUN on start=1; RUN->IDLE on start=0.
- Entering RUN clears n, zone index, zone sample counter and write pointer.
- Leaving RUN clears all pipeline valids; next cycle dout=0, dout_valid=0. In-flight samples are dropped.
- Accepted sample: written at wp; wp++ (wraps at 2^BUF_AW); n++, saturating at 2^BUF_AW.
- Delay lookup: {c,f}=LUT[zone]. c > 2^BUF_AW-2 is clamped to 2^BUF_AW-2.
  - x0 = sample n-c; x1 = sample n-c-1.
  - Any index <0 (n-c-1<0 or n-c<0) reads 0.
- Zone advance: zone sample counter increments per accepted sample. At ZONE_LEN, zone++ (saturating at 2^LUT_AW-1) and the counter reloads 0. The new zone applies from the next sample.
- Fine: y = x0 + (((x1-x0)*f + 2^(FD_WD-1)) >>> FD_WD); y width INPUT_WD+1.
- Apodization: p = y*apo (full width); r = (p + 2^(APO_SHIFT-1)) >>> APO_SHIFT; dout = r fitted to OUT_WD.
- cd_dout = x0, valid with stage 1.
- Latency: exactly 4 clk from accepting cycle to dout_valid.
  - S1: buffer/LUT read. S2: diff*frac. S3: sum. S4: apodize.
  - Full throughput, 1 sample/clk; dout holds the last value when no new valid.
- LUT write during RUN: read-before-write; a write to the current zone's entry takes effect from the next sample.
- tx_en=1 in RUN: no writes, no counter advance, no outputs.
- Reset mid-operation: immediate clear per reset values.

Optional Feature:
Macro DBF_SATURATE_EN.
- Defined: r is clamped to [-2^(OUT_WD-1), 2^(OUT_WD-1)-1].
- Undefined: r is truncated to its low OUT_WD bits (two's-complement wrap).

Decomposition:
- Package dbf_pkg: default widths, derived Y_WD=INPUT_WD+1, P_WD=Y_WD+APO_WD, LUT entry typedef {coarse, frac}, FSM state enum.
- Sub-module dbf_fine_interp: stages S2-S3, parameters INPUT_WD and FD_WD.

Test Plan:
- Impulse: LUT[0]={5,0}, apo=4096, din=1000 at n=10, 0 elsewhere -> dout=1000 for sample n=15, 4 clk after its acceptance; all other outputs 0.
- Interpolation: ramp din=100·n, LUT[0]={3,8}, apo=4096 -> dout=100n-350 once n≥4; n<3 -> 0.
- Zones: LUT[0]={2,0}, LUT[1]={6,0}, ramp 100·n, apo=4096 -> n 2..15 give 100(n-2); n≥16 give 100(n-6); zero where index<0.
- Saturation: din=8191 constant, LUT[0]={0,0}, apo=32767 -> with DBF_SATURATE_EN dout=32767; without, dout=-10.
- Abort/restart: drop start at n=20 -> next clk dout_valid=0, dout=0; raise start again -> n and zone restart at 0, first valid 4 clk after first accepted sample.
- tx_en/reset: tx_en=1 with din_valid=1 -> no dout_valid, counters frozen; rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dbf_pkg.sv
// dbf_pkg: shared default widths, derived datapath widths, the delay LUT entry
// layout and the channel FSM states for the beamforming channel.
package dbf_pkg;

  localparam int DBF_INPUT_WD  = 14;
  localparam int DBF_APO_WD    = 16;
  localparam int DBF_APO_SHIFT = 12;
  localparam int DBF_OUT_WD    = 16;
  localparam int DBF_BUF_AW    = 7;
  localparam int DBF_CD_WD     = 7;
  localparam int DBF_FD_WD     = 4;
  localparam int DBF_LUT_AW    = 6;
  localparam int DBF_ZONE_LEN  = 16;

  // Interpolated sample carries one guard bit; the apodization product is full width.
  localparam int Y_WD = DBF_INPUT_WD + 1;
  localparam int P_WD = Y_WD + DBF_APO_WD;

  // One delay LUT word: coarse sample delay in the upper bits, fraction below.
  typedef struct packed {
    logic [DBF_CD_WD-1:0] coarse;
    logic [DBF_FD_WD-1:0] frac;
  } lut_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dbf_state_e;

endpackage

// File: rtl/dbf_fine_interp.sv
// dbf_fine_interp: fine-delay stages. S2 forms (x1-x0)*frac, S3 adds the
// rounded, scaled difference back onto x0. A flush empties both stages.
module dbf_fine_interp #(
  parameter int INPUT_WD = 14,
  parameter int FD_WD    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic signed [INPUT_WD-1:0] x0,
  input  logic signed [INPUT_WD-1:0] x1,
  input  logic [FD_WD-1:0]           frac,
  output logic signed [INPUT_WD:0]   y,
  output logic                       y_valid
);

  localparam int DF_WD = INPUT_WD + 1;
  localparam int PR_WD = DF_WD + FD_WD + 1;
  localparam int HALF  = 2 ** (FD_WD - 1);

  logic signed [DF_WD-1:0]    diff;
  logic signed [FD_WD:0]      frac_s;
  logic signed [PR_WD-1:0]    prod_d;
  logic signed [PR_WD-1:0]    s2_prod;
  logic signed [PR_WD-1:0]    s2_round;
  logic signed [INPUT_WD-1:0] s2_x0;
  logic                       s2_valid;

  // Signed difference times the unsigned fraction, plus the rounding offset for S3.
  always_comb begin
    diff     = DF_WD'(x1) - DF_WD'(x0);
    frac_s   = {1'b0, frac};
    prod_d   = PR_WD'(diff) * PR_WD'(frac_s);
    s2_round = s2_prod + PR_WD'(HALF);
  end

  // S2: register the product and carry x0 alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_x0    <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= in_valid;
      if (in_valid) begin
        s2_prod <= prod_d;
        s2_x0   <= x0;
      end
    end
  end

  // S3: y = x0 + round(diff*frac / 2^FD_WD), arithmetic shift keeps the sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y       <= '0;
    end else if (flush) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= s2_valid;
      if (s2_valid) begin
        y <= DF_WD'(s2_x0) + DF_WD'(s2_round >>> FD_WD);
      end
    end
  end

endmodule

// File: rtl/dbf_ch_param.sv
// dbf_ch_param: one beamforming channel. Coarse delay from a circular sample
// buffer, fine delay by 2-tap interpolation, then apodization with rounding.
// Delay comes from a per-zone {coarse, frac} LUT, zone advancing every ZONE_LEN
// accepted samples. Four-stage pipeline: S1 read, S2 multiply, S3 sum, S4 apodize.
// Build option: define DBF_SATURATE_EN to clamp the output to OUT_WD instead of
// wrapping it in two's complement.
module dbf_ch_param
  import dbf_pkg::*;
#(
  parameter int INPUT_WD  = DBF_INPUT_WD,
  parameter int APO_WD    = DBF_APO_WD,
  parameter int APO_SHIFT = DBF_APO_SHIFT,
  parameter int OUT_WD    = DBF_OUT_WD,
  parameter int BUF_AW    = DBF_BUF_AW,
  parameter int CD_WD     = DBF_CD_WD,
  parameter int FD_WD     = DBF_FD_WD,
  parameter int LUT_AW    = DBF_LUT_AW,
  parameter int ZONE_LEN  = DBF_ZONE_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tx_en,
  input  logic                       start,
  input  logic signed [INPUT_WD-1:0] din,
  input  logic                       din_valid,
  input  logic signed [APO_WD-1:0]   apo_din,
  input  logic                       lut_we,
  input  logic [LUT_AW-1:0]          lut_addr,
  input  logic [CD_WD+FD_WD-1:0]     lut_din,
  output logic signed [OUT_WD-1:0]   dout,
  output logic                       dout_valid,
  output logic signed [INPUT_WD-1:0] cd_dout
);

  localparam int Y_BITS = INPUT_WD + 1;
  localparam int P_BITS = Y_BITS + APO_WD;
  localparam int R_BITS = P_BITS + 1;
  localparam int DEPTH  = 2 ** BUF_AW;
  localparam int C_MAX  = DEPTH - 2;
  localparam int N_AW   = BUF_AW + 1;
  localparam int ZC_WD  = $clog2(ZONE_LEN + 1);
  localparam int A_HALF = 2 ** (APO_SHIFT - 1);
  localparam logic [LUT_AW-1:0] ZONE_MAX = '1;
`ifdef DBF_SATURATE_EN
  localparam logic signed [R_BITS-1:0] R_MAX = R_BITS'(2 ** (OUT_WD - 1) - 1);
  localparam logic signed [R_BITS-1:0] R_MIN = R_BITS'(-(2 ** (OUT_WD - 1)));
`endif

  dbf_state_e state_q, state_d;
  logic leave_run;
  logic accept;

  logic [BUF_AW-1:0] wp;
  logic [N_AW-1:0]   n;
  logic [LUT_AW-1:0] zone;
  logic [ZC_WD-1:0]  zcnt;

  logic [CD_WD+FD_WD-1:0]     lut_mem [2**LUT_AW];
  logic signed [INPUT_WD-1:0] buf_mem [DEPTH];

  logic [CD_WD+FD_WD-1:0]     lut_rd;
  logic [CD_WD-1:0]           c_raw;
  logic [FD_WD-1:0]           f_raw;
  logic [BUF_AW-1:0]          c_eff;
  logic signed [INPUT_WD-1:0] x0_d, x1_d;

  logic signed [INPUT_WD-1:0] s1_x0, s1_x1;
  logic [FD_WD-1:0]           s1_f;
  logic signed [APO_WD-1:0]   s1_apo, s2_apo, s3_apo;
  logic                       s1_valid;
  logic signed [Y_BITS-1:0]   s3_y;
  logic                       s3_valid;

  logic signed [P_BITS-1:0]   prod4;
  logic signed [R_BITS-1:0]   r_sum, r_full;
  logic signed [OUT_WD-1:0]   r_fit;

  assign accept  = din_valid & ~tx_en & start;
  assign cd_dout = s1_x0;

  // Channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state follows start; dropping start while running flushes the pipeline.
  always_comb begin
    state_d   = state_q;
    leave_run = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (!start) begin
          state_d   = ST_IDLE;
          leave_run = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Delay LUT storage; reads are combinational so a same-cycle write is seen next sample.
  always_ff @(posedge clk) begin
    if (lut_we) lut_mem[lut_addr] <= lut_din;
  end

  // Circular sample buffer written at the write pointer on every accepted sample.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wp] <= din;
  end

  // Pointer, sample count and zone counters; held clear whenever start is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp   <= '0;
      n    <= '0;
      zone <= '0;
      zcnt <= '0;
    end else if (!start) begin
      wp   <= '0;
      n    <= '0;
      zone <= '0;
      zcnt <= '0;
    end else if (accept) begin
      wp <= wp + BUF_AW'(1);
      if (n != N_AW'(DEPTH)) n <= n + N_AW'(1);
      if (zcnt == ZC_WD'(ZONE_LEN - 1)) begin
        zcnt <= '0;
        if (zone != ZONE_MAX) zone <= zone + LUT_AW'(1);
      end else begin
        zcnt <= zcnt + ZC_WD'(1);
      end
    end
  end

  // Look up the zone delay, clamp coarse, and fetch taps n-c and n-c-1 (zero before sample 0).
  always_comb begin
    lut_rd = lut_mem[zone];
    c_raw  = lut_rd[CD_WD+FD_WD-1:FD_WD];
    f_raw  = lut_rd[FD_WD-1:0];
    c_eff  = (int'(c_raw) > C_MAX) ? BUF_AW'(C_MAX) : BUF_AW'(c_raw);
    x0_d   = '0;
    x1_d   = '0;
    if ({1'b0, c_eff} <= n) x0_d = (c_eff == '0) ? din : buf_mem[wp - c_eff];
    if ({1'b0, c_eff} < n)  x1_d = buf_mem[wp - c_eff - BUF_AW'(1)];
  end

  // S1: capture the taps, fraction and weight of the accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x0    <= '0;
      s1_x1    <= '0;
      s1_f     <= '0;
      s1_apo   <= '0;
    end else if (leave_run) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x0  <= x0_d;
        s1_x1  <= x1_d;
        s1_f   <= f_raw;
        s1_apo <= apo_din;
      end
    end
  end

  // Weight travels beside the fixed-latency interpolator so it lines up at S4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_apo <= '0;
      s3_apo <= '0;
    end else begin
      s2_apo <= s1_apo;
      s3_apo <= s2_apo;
    end
  end

  dbf_fine_interp #(
    .INPUT_WD (INPUT_WD),
    .FD_WD    (FD_WD)
  ) u_fine (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (leave_run),
    .in_valid (s1_valid),
    .x0       (s1_x0),
    .x1       (s1_x1),
    .frac     (s1_f),
    .y        (s3_y),
    .y_valid  (s3_valid)
  );

  // Apodize with round-half-up, then fit the result to the output width.
  always_comb begin
    prod4  = P_BITS'(s3_y) * P_BITS'(s3_apo);
    r_sum  = R_BITS'(prod4) + R_BITS'(A_HALF);
    r_full = r_sum >>> APO_SHIFT;
`ifdef DBF_SATURATE_EN
    if (r_full > R_MAX)      r_fit = OUT_WD'(R_MAX);
    else if (r_full < R_MIN) r_fit = OUT_WD'(R_MIN);
    else                     r_fit = OUT_WD'(r_full);
`else
    r_fit = OUT_WD'(r_full);
`endif
  end

  // S4 output register: holds the last value between valids, zeroed when leaving RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (leave_run) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s3_valid;
      if (s3_valid) dout <= r_fit;
    end
  end

endmodule

// File: tb/tb_dbf_ch_param.sv
// tb_dbf_ch_param: directed tests for the beamforming channel: reset, impulse
// through coarse delay, interpolation, zone switching, output fitting,
// abort/restart, transmit blanking and asynchronous reset mid-stream.
module tb_dbf_ch_param;
  import dbf_pkg::*;

  localparam int INPUT_WD = 14;
  localparam int APO_WD   = 16;
  localparam int OUT_WD   = 16;
  localparam int CD_WD    = 7;
  localparam int FD_WD    = 4;
  localparam int LUT_AW   = 6;

  logic clk = 1'b0;
  logic rst_n, tx_en, start, din_valid, lut_we, dout_valid;
  logic signed [INPUT_WD-1:0] din, cd_dout;
  logic signed [APO_WD-1:0]   apo_din;
  logic [LUT_AW-1:0]          lut_addr;
  logic [CD_WD+FD_WD-1:0]     lut_din;
  logic signed [OUT_WD-1:0]   dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dbf_ch_param dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .apo_din    (apo_din),
    .lut_we     (lut_we),
    .lut_addr   (lut_addr),
    .lut_din    (lut_din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .cd_dout    (cd_dout)
  );

  // One clock: inputs change on the falling edge, outputs read 1 time unit after the rising edge.
  task automatic drive_cycle(input logic v, input int d, input logic tx, input logic st);
    @(negedge clk);
    din_valid = v;
    din       = INPUT_WD'(d);
    tx_en     = tx;
    start     = st;
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input int addr, input int c, input int f);
    lut_entry_t e;
    e.coarse = CD_WD'(c);
    e.frac   = FD_WD'(f);
    @(negedge clk);
    lut_we   = 1'b1;
    lut_addr = LUT_AW'(addr);
    lut_din  = e;
    @(posedge clk);
    #1;
    lut_we = 1'b0;
  endtask

  // Idle one clock with start low, then raise start with no sample.
  task automatic begin_run();
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_en = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0;
    apo_din = '0; lut_we = 1'b0; lut_addr = '0; lut_din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dout !== 16'sd0) begin n_errors++; $display("[TB] FAIL reset_dout: got %0d, expected 0", dout); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_valid: got %0b, expected 0", dout_valid); end
    n_checks++;
    if (cd_dout !== 14'sd0) begin n_errors++; $display("[TB] FAIL reset_cd_dout: got %0d, expected 0", cd_dout); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Impulse of 1000 at n=10 through coarse delay 5 must reappear at n=15 only.
  task automatic test_impulse();
    int ev, ed;
    lut_write(0, 5, 0);
    lut_write(1, 5, 0);
    apo_din = 16'sd4096;
    begin_run();
    for (int i = 0; i < 21; i++) begin
      drive_cycle(i < 16, (i == 10) ? 1000 : 0, 1'b0, 1'b1);
      if (i < 16) begin
        n_checks++;
        if (cd_dout !== INPUT_WD'((i == 15) ? 1000 : 0)) begin
          n_errors++;
          $display("[TB] FAIL impulse_cd_dout i=%0d: got %0d, expected %0d", i, cd_dout, (i == 15) ? 1000 : 0);
        end
      end
      ev = (i >= 3 && i < 19) ? 1 : 0;
      ed = (i < 19) ? (((i - 3) == 15) ? 1000 : 0) : 1000;
      n_checks++;
      if (dout_valid !== ev[0] || (i >= 3 && dout !== OUT_WD'(ed))) begin
        n_errors++;
        $display("[TB] FAIL impulse_out i=%0d: got valid=%0b dout=%0d, expected valid=%0d dout=%0d", i, dout_valid, dout, ev, ed);
      end
    end
  endtask

  // Ramp 100*n with delay 3 + 8/16: half-way between samples n-3 and n-4, rounded.
  task automatic test_interp();
    int ev, ed, k;
    lut_write(0, 3, 8);
    lut_write(1, 3, 8);
    apo_din = 16'sd4096;
    begin_run();
    for (int i = 0; i < 21; i++) begin
      drive_cycle(i < 16, 100 * i, 1'b0, 1'b1);
      k  = (i < 19) ? i - 3 : 15;
      ev = (i >= 3 && i < 19) ? 1 : 0;
      ed = (k >= 4) ? 100 * k - 350 : 0;
      n_checks++;
      if (dout_valid !== ev[0] || (i >= 3 && dout !== OUT_WD'(ed))) begin
        n_errors++;
        $display("[TB] FAIL interp_out i=%0d: got valid=%0b dout=%0d, expected valid=%0d dout=%0d", i, dout_valid, dout, ev, ed);
      end
    end
  endtask

  // Zone 0 uses delay 2, zone 1 (from n=16) uses delay 6.
  task automatic test_zones();
    int ev, ed, k;
    lut_write(0, 2, 0);
    lut_write(1, 6, 0);
    apo_din = 16'sd4096;
    begin_run();
    for (int i = 0; i < 29; i++) begin
      drive_cycle(i < 24, 100 * i, 1'b0, 1'b1);
      k  = (i < 27) ? i - 3 : 23;
      ev = (i >= 3 && i < 27) ? 1 : 0;
      ed = (k < 2) ? 0 : (k < 16) ? 100 * (k - 2) : 100 * (k - 6);
      n_checks++;
      if (dout_valid !== ev[0] || (i >= 3 && dout !== OUT_WD'(ed))) begin
        n_errors++;
        $display("[TB] FAIL zones_out i=%0d: got valid=%0b dout=%0d, expected valid=%0d dout=%0d", i, dout_valid, dout, ev, ed);
      end
    end
  endtask

  // 8191 * 32767 rounds to 65526, which overflows a 16-bit signed output.
  task automatic test_saturate();
    int ed;
`ifdef DBF_SATURATE_EN
    ed = 32767;
`else
    ed = -10;
`endif
    lut_write(0, 0, 0);
    lut_write(1, 0, 0);
    apo_din = 16'sd32767;
    begin_run();
    for (int i = 0; i < 11; i++) begin
      drive_cycle(i < 8, 8191, 1'b0, 1'b1);
      if (i >= 3 && i < 11) begin
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== OUT_WD'(ed)) begin
          n_errors++;
          $display("[TB] FAIL saturate_out i=%0d: got valid=%0b dout=%0d, expected valid=1 dout=%0d", i, dout_valid, dout, ed);
        end
      end
    end
  endtask

  // Drop start mid-stream, check the flush, then restart and check counters began again at zero.
  task automatic test_abort_restart();
    int ed, k;
    lut_write(0, 2, 0);
    lut_write(1, 6, 0);
    apo_din = 16'sd4096;
    begin_run();
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 100 * i, 1'b0, 1'b1);
      if (i >= 3) begin
        k  = i - 3;
        ed = (k < 2) ? 0 : (k < 16) ? 100 * (k - 2) : 100 * (k - 6);
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== OUT_WD'(ed)) begin
          n_errors++;
          $display("[TB] FAIL abort_stream i=%0d: got valid=%0b dout=%0d, expected valid=1 dout=%0d", i, dout_valid, dout, ed);
        end
      end
    end
    drive_cycle(1'b1, 2000, 1'b0, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b0 || dout !== 16'sd0) begin
      n_errors++;
      $display("[TB] FAIL abort_flush: got valid=%0b dout=%0d, expected valid=0 dout=0", dout_valid, dout);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
      n_checks++;
      if (dout_valid !== 1'b0 || dout !== 16'sd0) begin
        n_errors++;
        $display("[TB] FAIL abort_dropped i=%0d: got valid=%0b dout=%0d, expected valid=0 dout=0", i, dout_valid, dout);
      end
    end
    drive_cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      drive_cycle(i < 8, 100 * i, 1'b0, 1'b1);
      k = i - 3;
      ed = (k < 2) ? 0 : 100 * (k - 2);
      n_checks++;
      if (i < 3 || i >= 11) begin
        if (dout_valid !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL restart_latency i=%0d: got valid=%0b, expected valid=0", i, dout_valid);
        end
      end else if (dout_valid !== 1'b1 || dout !== OUT_WD'(ed)) begin
        n_errors++;
        $display("[TB] FAIL restart_out i=%0d: got valid=%0b dout=%0d, expected valid=1 dout=%0d", i, dout_valid, dout, ed);
      end
    end
  endtask

  // Blank samples with tx_en, resume the ramp, then pull reset low between clock edges.
  task automatic test_tx_reset();
    int acc [19];
    int nxt, k, ed;
    logic ev;
    nxt = 0;
    lut_write(0, 2, 0);
    apo_din = 16'sd4096;
    begin_run();
    for (int i = 0; i < 19; i++) begin
      if (i >= 5 && i < 11) begin
        drive_cycle(1'b1, 7777, 1'b1, 1'b1);
        acc[i] = -1;
      end else begin
        drive_cycle(1'b1, 100 * nxt, 1'b0, 1'b1);
        acc[i] = nxt;
        nxt++;
      end
      k  = (i >= 3) ? acc[i-3] : -1;
      ev = (k >= 0);
      ed = (k >= 2) ? 100 * (k - 2) : 0;
      n_checks++;
      if (dout_valid !== ev || (ev && dout !== OUT_WD'(ed))) begin
        n_errors++;
        $display("[TB] FAIL tx_out i=%0d: got valid=%0b dout=%0d, expected valid=%0b dout=%0d", i, dout_valid, dout, ev, ed);
      end
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dout !== 16'sd0 || dout_valid !== 1'b0 || cd_dout !== 14'sd0) begin
      n_errors++;
      $display("[TB] FAIL async_reset: got dout=%0d valid=%0b cd_dout=%0d, expected all 0", dout, dout_valid, cd_dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    n_checks++;
    if (dout !== 16'sd0 || dout_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL post_reset: got dout=%0d valid=%0b, expected 0 and 0", dout, dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_interp();
    test_zones();
    test_saturate();
    test_abort_restart();
    test_tx_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
